// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the shared
// datapath strobes, waits on the memory ready handshakes with a watchdog that
// aborts stalled accesses, and counts retired instructions (one per pc_wr).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FETCH  | request instruction, load IR when imem_rdy
//   S_DECODE | J/JR retire here, JAL skips to WB, illegal retires as NOP
//   S_EXEC   | ALU operation; branches resolve and retire here
//   S_MEM    | LW/SW data access, SW retires on dmem_rdy
//   S_WB     | register write-back and PC update
module multicycle_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    output logic             imem_rd,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       sel_pc,
    output logic [1:0]       sel_dest,
    output logic             wr_en,
    output logic             sel_opB,
    output logic [5:0]       alu_op,
    output logic [1:0]       sel_data,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SLT = 6'b101010;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  retired_q;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic is_r, is_r_alu, is_jr, is_j, is_jal, is_beq, is_bne;
    logic is_addi, is_slti, is_lw, is_sw, is_branch, is_exec;

    // Instruction class decode from the held IR fields.
    always_comb begin
        is_r      = (opcode == OP_R);
        is_r_alu  = is_r && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT) ||
                             (funct == FN_SLL) || (funct == FN_SRL));
        is_jr     = is_r && (funct == FN_JR);
        is_j      = (opcode == OP_J);
        is_jal    = (opcode == OP_JAL);
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_addi   = (opcode == OP_ADDI);
        is_slti   = (opcode == OP_SLTI);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        is_branch = is_beq || is_bne;
        is_exec   = is_r_alu || is_addi || is_slti || is_lw || is_sw || is_branch;
    end

    // Next-state, watchdog and datapath strobes; everything is held low in reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        imem_rd   = 1'b0;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        sel_pc    = 2'd0;
        sel_dest  = 2'd0;
        wr_en     = 1'b0;
        sel_opB   = 1'b0;
        alu_op    = 6'd0;
        sel_data  = 2'd0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_rd = 1'b1;
                if (imem_rdy) begin
                    ir_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == WAIT_LAST) begin
                    // Abort and refetch the same PC; nothing retires.
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_wr   = 1'b1;
                    sel_pc  = 2'd2;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    sel_pc  = 2'd3;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else if (is_exec) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    pc_wr     = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_r)           alu_op = funct;
                else if (is_slti)   alu_op = ALU_SLT;
                else if (is_branch) alu_op = opcode;
                else                alu_op = ALU_ADD;
                sel_opB = !(is_r || is_branch);
                if (is_branch) begin
                    pc_wr   = 1'b1;
                    sel_pc  = ((is_beq && zero) || (is_bne && !zero)) ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_op  = ALU_ADD;
                sel_opB = 1'b1;
                dmem_rd = is_lw;
                dmem_wr = is_sw;
                if (dmem_rdy) begin
                    if (is_sw) begin
                        pc_wr   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                wr_en   = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
                if (is_jal) begin
                    sel_dest = 2'd2;
                    sel_data = 2'd2;
                    sel_pc   = 2'd2;
                end else if (is_lw) begin
                    sel_dest = 2'd1;
                    sel_data = 2'd1;
                end else if (is_addi || is_slti) begin
                    sel_dest = 2'd1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) cnt_d = '0;

        if (!nrst) begin
            imem_rd  = 1'b0;
            ir_wr    = 1'b0;
            pc_wr    = 1'b0;
            sel_pc   = 2'd0;
            sel_dest = 2'd0;
            wr_en    = 1'b0;
            sel_opB  = 1'b0;
            alu_op   = 6'd0;
            sel_data = 2'd0;
            dmem_rd  = 1'b0;
            dmem_wr  = 1'b0;
        end
    end

    // State, watchdog, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (pc_wr) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each stimulus cycle pushes its
// hand-computed output vector into a queue; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLL = 6'b000000;
    localparam logic [5:0] F_JR = 6'b001000;
    localparam logic [5:0] A_ADD = 6'b100000, A_SLT = 6'b101010;

    logic        clk = 1'b0;
    logic        nrst, zero, imem_rdy, dmem_rdy;
    logic [5:0]  opcode, funct;
    logic        imem_rd, ir_wr, pc_wr, wr_en, sel_opB, dmem_rd, dmem_wr, illegal, bus_err;
    logic [1:0]  sel_pc, sel_dest, sel_data;
    logic [5:0]  alu_op;
    logic [31:0] retired;

    multicycle_ctrl #(.WAIT_MAX(16), .CNT_W(32)) dut (
        .clk(clk), .nrst(nrst), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_rd(imem_rd), .ir_wr(ir_wr),
        .pc_wr(pc_wr), .sel_pc(sel_pc), .sel_dest(sel_dest), .wr_en(wr_en),
        .sel_opB(sel_opB), .alu_op(alu_op), .sel_data(sel_data), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] o;
        logic        chk;
        logic [31:0] ret;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic ill_e = 1'b0, be_e = 1'b0;
    int   r_e = 0;

    function automatic logic [18:0] pk(input logic imr, irw, pcw, input logic [1:0] spc, sd,
                                       input logic we, ob, input logic [5:0] alu,
                                       input logic [1:0] sdat, input logic dr, dw);
        return {imr, irw, pcw, spc, sd, we, ob, alu, sdat, dr, dw};
    endfunction

    task automatic cyc(input logic rn, ri, rd, z, input logic [5:0] op, fn,
                       input logic [18:0] eo, input logic chk, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        nrst = rn; imem_rdy = ri; dmem_rdy = rd; zero = z; opcode = op; funct = fn;
        x.o = {eo, ill_e, be_e};
        x.chk = chk;
        x.ret = 32'(r_e);
        x.tag = tag;
        q.push_back(x);
    endtask

    // Monitor: one queued expectation per cycle, compared at the falling edge.
    exp_t        m;
    logic [20:0] got, msk;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            got = {imem_rd, ir_wr, pc_wr, sel_pc, sel_dest, wr_en, sel_opB, alu_op,
                   sel_data, dmem_rd, dmem_wr, illegal, bus_err};
            msk = m.chk ? 21'h1fffff : 21'h1ffffc;
            checks++;
            if (((got ^ m.o) & msk) !== 21'h0) begin
                failures++;
                $display("FAIL %s outputs got=%h exp=%h mask=%h t=%0t", m.tag, got, m.o, msk, $time);
            end
            if (m.chk) begin
                checks++;
                if (retired !== m.ret) begin
                    failures++;
                    $display("FAIL %s retired got=%0d exp=%0d t=%0t", m.tag, retired, m.ret, $time);
                end
            end
        end
    end

    logic [18:0] NONE, F_ACK, F_WAIT, W_R, W_I;

    initial begin
        NONE   = pk(0,0,0,0,0,0,0,6'd0,0,0,0);
        F_ACK  = pk(1,1,0,0,0,0,0,6'd0,0,0,0);
        F_WAIT = pk(1,0,0,0,0,0,0,6'd0,0,0,0);
        W_R    = pk(0,0,1,0,0,1,0,6'd0,0,0,0);
        W_I    = pk(0,0,1,0,1,1,0,6'd0,0,0,0);
        nrst = 1'b0; imem_rdy = 1'b1; dmem_rdy = 1'b1; zero = 1'b0;
        opcode = 6'd0; funct = 6'd0;

        cyc(0,1,1,0, OP_R, F_ADD, NONE, 0, "rst0");
        cyc(0,1,1,0, OP_R, F_ADD, NONE, 0, "rst1");

        // ADD, ready tied high
        cyc(1,1,1,0, OP_R, F_ADD, F_ACK, 1, "add_f");
        cyc(1,1,1,0, OP_R, F_ADD, NONE, 1, "add_d");
        cyc(1,1,1,0, OP_R, F_ADD, pk(0,0,0,0,0,0,0,F_ADD,0,0,0), 1, "add_e");
        cyc(1,1,1,0, OP_R, F_ADD, W_R, 1, "add_w");
        r_e++;

        // LW with dmem_rdy low for 3 cycles
        cyc(1,1,1,0, OP_LW, 6'd5, F_ACK, 1, "lw_f");
        cyc(1,1,1,0, OP_LW, 6'd5, NONE, 1, "lw_d");
        cyc(1,1,1,0, OP_LW, 6'd5, pk(0,0,0,0,0,0,1,A_ADD,0,0,0), 1, "lw_e");
        for (int i = 0; i < 3; i++)
            cyc(1,1,0,0, OP_LW, 6'd5, pk(0,0,0,0,0,0,1,A_ADD,0,1,0), 1, "lw_mwait");
        cyc(1,1,1,0, OP_LW, 6'd5, pk(0,0,0,0,0,0,1,A_ADD,0,1,0), 1, "lw_mrdy");
        cyc(1,1,1,0, OP_LW, 6'd5, pk(0,0,1,0,1,1,0,6'd0,1,0,0), 1, "lw_w");
        r_e++;

        // BEQ taken, BNE not taken (zero=1 both)
        cyc(1,1,1,1, OP_BEQ, 6'd0, F_ACK, 1, "beq_f");
        cyc(1,1,1,1, OP_BEQ, 6'd0, NONE, 1, "beq_d");
        cyc(1,1,1,1, OP_BEQ, 6'd0, pk(0,0,1,1,0,0,0,OP_BEQ,0,0,0), 1, "beq_e");
        r_e++;
        cyc(1,1,1,1, OP_BNE, 6'd0, F_ACK, 1, "bne_f");
        cyc(1,1,1,1, OP_BNE, 6'd0, NONE, 1, "bne_d");
        cyc(1,1,1,1, OP_BNE, 6'd0, pk(0,0,1,0,0,0,0,OP_BNE,0,0,0), 1, "bne_e");
        r_e++;

        // JAL, J, JR
        cyc(1,1,1,0, OP_JAL, 6'd0, F_ACK, 1, "jal_f");
        cyc(1,1,1,0, OP_JAL, 6'd0, NONE, 1, "jal_d");
        cyc(1,1,1,0, OP_JAL, 6'd0, pk(0,0,1,2,2,1,0,6'd0,2,0,0), 1, "jal_w");
        r_e++;
        cyc(1,1,1,0, OP_J, 6'd0, F_ACK, 1, "j_f");
        cyc(1,1,1,0, OP_J, 6'd0, pk(0,0,1,2,0,0,0,6'd0,0,0,0), 1, "j_d");
        r_e++;
        cyc(1,1,1,0, OP_R, F_JR, F_ACK, 1, "jr_f");
        cyc(1,1,1,0, OP_R, F_JR, pk(0,0,1,3,0,0,0,6'd0,0,0,0), 1, "jr_d");
        r_e++;

        // SW, memory ready at once
        cyc(1,1,1,0, OP_SW, 6'd0, F_ACK, 1, "sw_f");
        cyc(1,1,1,0, OP_SW, 6'd0, NONE, 1, "sw_d");
        cyc(1,1,1,0, OP_SW, 6'd0, pk(0,0,0,0,0,0,1,A_ADD,0,0,0), 1, "sw_e");
        cyc(1,1,1,0, OP_SW, 6'd0, pk(0,0,1,0,0,0,1,A_ADD,0,0,1), 1, "sw_m");
        r_e++;

        // Unsupported opcode retires as NOP and sets illegal
        cyc(1,1,1,0, OP_BAD, 6'd0, F_ACK, 1, "ill_f");
        cyc(1,1,1,0, OP_BAD, 6'd0, pk(0,0,1,0,0,0,0,6'd0,0,0,0), 1, "ill_d");
        r_e++;
        ill_e = 1'b1;

        // ADDI: ready arrives in the last watchdog cycle and wins over expiry
        for (int i = 0; i < 15; i++)
            cyc(1,0,1,0, OP_ADDI, 6'd0, F_WAIT, 1, "addi_fwait");
        cyc(1,1,1,0, OP_ADDI, 6'd0, F_ACK, 1, "addi_f_edge");
        cyc(1,1,1,0, OP_ADDI, 6'd0, NONE, 1, "addi_d");
        cyc(1,1,1,0, OP_ADDI, 6'd0, pk(0,0,0,0,0,0,1,A_ADD,0,0,0), 1, "addi_e");
        cyc(1,1,1,0, OP_ADDI, 6'd0, W_I, 1, "addi_w");
        r_e++;

        // SLTI
        cyc(1,1,1,0, OP_SLTI, 6'd0, F_ACK, 1, "slti_f");
        cyc(1,1,1,0, OP_SLTI, 6'd0, NONE, 1, "slti_d");
        cyc(1,1,1,0, OP_SLTI, 6'd0, pk(0,0,0,0,0,0,1,A_SLT,0,0,0), 1, "slti_e");
        cyc(1,1,1,0, OP_SLTI, 6'd0, W_I, 1, "slti_w");
        r_e++;

        // Watchdog expiry: 16 FETCH cycles without ready
        for (int i = 0; i < 16; i++)
            cyc(1,0,1,0, OP_R, F_SUB, F_WAIT, 1, "wd_fwait");
        be_e = 1'b1;
        cyc(1,0,1,0, OP_R, F_SUB, F_WAIT, 1, "wd_after");
        cyc(1,1,1,0, OP_R, F_SUB, F_ACK, 1, "sub_f");
        cyc(1,1,1,0, OP_R, F_SUB, NONE, 1, "sub_d");
        cyc(1,1,1,0, OP_R, F_SUB, pk(0,0,0,0,0,0,0,F_SUB,0,0,0), 1, "sub_e");
        cyc(1,1,1,0, OP_R, F_SUB, W_R, 1, "sub_w");
        r_e++;

        // Reset while SW is waiting in MEM
        cyc(1,1,0,0, OP_SW, 6'd0, F_ACK, 1, "swr_f");
        cyc(1,1,0,0, OP_SW, 6'd0, NONE, 1, "swr_d");
        cyc(1,1,0,0, OP_SW, 6'd0, pk(0,0,0,0,0,0,1,A_ADD,0,0,0), 1, "swr_e");
        cyc(1,1,0,0, OP_SW, 6'd0, pk(0,0,0,0,0,0,1,A_ADD,0,0,1), 1, "swr_m");
        cyc(0,1,1,0, OP_SW, 6'd0, NONE, 0, "swr_rst");
        ill_e = 1'b0; be_e = 1'b0; r_e = 0;
        cyc(1,1,1,0, OP_R, F_SLL, F_ACK, 1, "post_rst_f");
        cyc(1,1,1,0, OP_R, F_SLL, NONE, 1, "sll_d");
        cyc(1,1,1,0, OP_R, F_SLL, NONE, 1, "sll_e");
        cyc(1,1,1,0, OP_R, F_SLL, W_R, 1, "sll_w");
        r_e++;
        cyc(1,0,1,0, OP_R, F_SLL, F_WAIT, 1, "final");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
